// File: rtl/halut_pkg.sv
// Shared HALUT decoder parameters and the default result-beat layout.
package halut_pkg;
  localparam int DecoderUnits  = 4;
  localparam int K             = 16;
  localparam int C             = 4;
  localparam int DataTypeWidth = 32;
  localparam int OutLanes      = 2;
  localparam int FifoDepth     = 4;

  localparam int TotalAddrWidth = $clog2(C * K);
  localparam int CAddrWidth     = $clog2(C);
  localparam int TreeDepth      = $clog2(K);
  localparam int DecAddrWidth   = $clog2(DecoderUnits);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  typedef struct packed {
    logic [OutLanes-1:0][31:0]             result;
    logic [OutLanes-1:0][DecAddrWidth-1:0] m_addr;
    logic [OutLanes-1:0]                   lane_valid;
  } halut_beat_t;
endpackage

// File: rtl/halut_decoder.sv
// Single HALUT decoder unit: private LUT, one registered lookup per start strobe.
module halut_decoder #(
  parameter int K                = 16,
  parameter int C                = 4,
  parameter int DataTypeWidth    = 32,
  localparam int TotalAddrWidth  = $clog2(C * K)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      we,
  input  logic [TotalAddrWidth-1:0] waddr,
  input  logic [DataTypeWidth-1:0]  wdata,
  input  logic                      start,
  input  logic [TotalAddrWidth-1:0] raddr,
  output logic                      valid,
  output logic [31:0]               result
);
  logic [DataTypeWidth-1:0] lut [C*K];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < C * K; i++) lut[i] <= '0;
      valid  <= 1'b0;
      result <= '0;
    end else begin
      valid <= start;
      if (we) lut[waddr] <= wdata;
      if (start) result <= 32'(lut[raddr]);
    end
  end
endmodule

// File: rtl/halut_result_fifo.sv
// Result FIFO with valid/ready on both sides; accepts a push while full if the head pops.
module halut_result_fifo #(
  parameter int  Depth = 4,
  parameter type T     = logic [31:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  localparam int PtrWidth = $clog2(Depth);

  T                    mem [Depth];
  logic [PtrWidth-1:0] wptr_q, rptr_q;
  logic [PtrWidth:0]   count_q;
  logic                push, pop;

  assign out_valid = count_q != '0;
  assign in_ready  = (count_q != (PtrWidth+1)'(Depth)) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= in_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + {{PtrWidth{1'b0}}, push} - {{PtrWidth{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/prim_onehot_enc.sv
// Binary index to one-hot select; indices beyond OneHotWidth select nothing.
module prim_onehot_enc #(
  parameter int OneHotWidth = 4,
  parameter int InputWidth  = $clog2(OneHotWidth)
) (
  input  logic [InputWidth-1:0]  idx,
  input  logic                   en,
  output logic [OneHotWidth-1:0] onehot
);
  always_comb begin
    onehot = '0;
    for (int i = 0; i < OneHotWidth; i++) onehot[i] = en && (idx == InputWidth'(i));
  end
endmodule

// File: rtl/halut_decoder_x_stream.sv
// HALUT decoder array feeding a back-pressured result stream.
// Define HALUT_DECODER_X_STREAM_PERF_EN to add the stall_cnt_o stall counter.
//   state   | meaning
//   IDLE    | cnt=0, no round in progress
//   ISSUE   | collecting slots cnt..cnt+OutLanes-1 into the next beat
module halut_decoder_x_stream #(
  parameter int  DecoderUnits   = halut_pkg::DecoderUnits,
  parameter int  K              = halut_pkg::K,
  parameter int  C              = halut_pkg::C,
  parameter int  DataTypeWidth  = halut_pkg::DataTypeWidth,
  parameter int  OutLanes       = halut_pkg::OutLanes,
  parameter int  FifoDepth      = halut_pkg::FifoDepth,
  localparam int TotalAddrWidth = $clog2(C * K),
  localparam int CAddrWidth     = $clog2(C),
  localparam int TreeDepth      = $clog2(K),
  localparam int DecAddrWidth   = $clog2(DecoderUnits)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [DecAddrWidth-1:0]          m_addr_i,
  input  logic [TotalAddrWidth-1:0]        waddr_i,
  input  logic [DataTypeWidth-1:0]         wdata_i,
  input  logic                             we_i,
  input  logic [CAddrWidth-1:0]            c_addr_i,
  input  logic [TreeDepth-1:0]             k_addr_i,
  input  logic                             decoder_i,
  output logic [OutLanes*32-1:0]           result_o,
  output logic [OutLanes*DecAddrWidth-1:0] m_addr_o,
  output logic [OutLanes-1:0]              lane_valid_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic                             overflow_o
`ifdef HALUT_DECODER_X_STREAM_PERF_EN
  ,output logic [31:0]                     stall_cnt_o
`endif
);
  localparam int CntWidth = $clog2(DecoderUnits + OutLanes);

  typedef struct packed {
    logic [OutLanes-1:0][31:0]             result;
    logic [OutLanes-1:0][DecAddrWidth-1:0] m_addr;
    logic [OutLanes-1:0]                   lane_valid;
  } beat_t;

  logic                      dec_q, start;
  logic [TotalAddrWidth-1:0] raddr, addr_q;
  logic [DecoderUnits-1:0]   wsel, unit_valid, slot_full, covered, drain, lost;
  logic [31:0]               unit_result [DecoderUnits];
  logic [31:0]               slot_data [DecoderUnits];
  logic [0:0]                state_q;
  logic [CntWidth-1:0]       cnt_q;
  logic                      all_full, push, fifo_ready, last_beat;
  beat_t                     beat, head;

  // C and K are powers of two, so the flat LUT index is a plain concatenation.
  assign raddr = {c_addr_i, k_addr_i};
  assign start = decoder_i && (!dec_q || (raddr != addr_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      dec_q  <= decoder_i;
      addr_q <= raddr;
    end
  end

  prim_onehot_enc #(.OneHotWidth(DecoderUnits), .InputWidth(DecAddrWidth)) u_wdec (
    .idx(m_addr_i), .en(we_i), .onehot(wsel)
  );

  for (genvar x = 0; x < DecoderUnits; x++) begin : g_unit
    halut_decoder #(.K(K), .C(C), .DataTypeWidth(DataTypeWidth)) u_unit (
      .clk_i, .rst_ni, .we(wsel[x]), .waddr(waddr_i), .wdata(wdata_i),
      .start, .raddr, .valid(unit_valid[x]), .result(unit_result[x])
    );
  end

  always_comb begin
    beat     = '0;
    covered  = '0;
    all_full = 1'b1;
    for (int l = 0; l < OutLanes; l++)
      for (int x = 0; x < DecoderUnits; x++)
        if (int'(cnt_q) + l == x) begin
          covered[x]         = 1'b1;
          beat.lane_valid[l] = 1'b1;
          beat.result[l]     = slot_data[x];
          beat.m_addr[l]     = DecAddrWidth'(x);
          all_full           = all_full & slot_full[x];
        end
  end

  assign push      = decoder_i && all_full && fifo_ready;
  assign drain     = push ? covered : '0;
  assign last_beat = covered[DecoderUnits-1];
  assign lost      = unit_valid & slot_full & ~drain & {DecoderUnits{decoder_i}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_full  <= '0;
      overflow_o <= 1'b0;
      for (int x = 0; x < DecoderUnits; x++) slot_data[x] <= '0;
    end else begin
      overflow_o <= overflow_o | (|lost);
      for (int x = 0; x < DecoderUnits; x++) begin
        if (!decoder_i) slot_full[x] <= 1'b0;
        else if (unit_valid[x] && (!slot_full[x] || drain[x])) begin
          slot_full[x] <= 1'b1;
          slot_data[x] <= unit_result[x];
        end else if (drain[x]) slot_full[x] <= 1'b0;
      end
    end
  end

  // The first beat may leave IDLE directly so a capture reaches the FIFO one edge later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= halut_pkg::StIdle;
      cnt_q   <= '0;
    end else if (!decoder_i) begin
      state_q <= halut_pkg::StIdle;
      cnt_q   <= '0;
    end else if (push) begin
      if (last_beat) begin
        state_q <= halut_pkg::StIdle;
        cnt_q   <= '0;
      end else begin
        state_q <= halut_pkg::StIssue;
        cnt_q   <= cnt_q + CntWidth'(OutLanes);
      end
    end else if (state_q == halut_pkg::StIdle && |slot_full) begin
      state_q <= halut_pkg::StIssue;
    end
  end

  halut_result_fifo #(.Depth(FifoDepth), .T(beat_t)) u_fifo (
    .clk_i, .rst_ni,
    .in_valid(push), .in_ready(fifo_ready), .in_data(beat),
    .out_valid(valid_o), .out_ready(ready_i), .out_data(head)
  );

  assign result_o     = head.result;
  assign m_addr_o     = head.m_addr;
  assign lane_valid_o = head.lane_valid;

`ifdef HALUT_DECODER_X_STREAM_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_o <= '0;
    else if (valid_o && !ready_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif
endmodule
